gate_tt_sequencer: RTL and testbench

Self-checking truth-table sequencer for small combinational gate blocks (or3, and3, and similar). It sweeps every input combination onto the gate under test and waits a programmable settle time. It then samples the gate output, compares it with a caller-supplied expected truth table, and reports the mismatch count, the first failing vector and a pass flag. It sits between a bring-up controller, or a bench top level, and one N-input, 1-output gate instance.

---
 rtl/gate_tt_sequencer.sv | 163 ++++++++++++++++
 tb/tb_gate_tt_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/gate_tt_sequencer.sv
// Truth-table sequencer for a small N-input, 1-output combinational gate.
// It sweeps every input vector onto the gate and holds each one for SETTLE
// cycles before sampling. It compares each sample with a latched expected
// table and reports the mismatch count, the first failing vector and a pass flag.
//
// Ports:
//   clk, rst_n   rising-edge clock, asynchronous active-low reset
//   start        request a sweep (accepted only when idle)
//   abort        cancel a running sweep (wins over start when idle)
//   expected_tt  bit i = expected gate output for input vector i
//   dut_in       registered drive to the gate inputs (MSB = input a)
//   dut_out      gate output under test
//   busy         sweep in progress
//   done         one-cycle pulse on sweep completion
//   pass         last completed sweep had no mismatches
//   err_count    mismatch count of current/last sweep
//   first_fail   lowest failing vector (meaningful when fail_valid)
//   fail_valid   at least one mismatch recorded in this sweep
module gate_tt_sequencer #(
  parameter int unsigned N_IN   = 3,
  parameter int unsigned SETTLE = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [(1<<N_IN)-1:0]    expected_tt,
  output logic [N_IN-1:0]         dut_in,
  input  logic                    dut_out,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [N_IN:0]           err_count,
  output logic [N_IN-1:0]         first_fail,
  output logic                    fail_valid
);

  localparam int unsigned NVEC = 1 << N_IN;
  localparam int unsigned CW   = 4;
  localparam int unsigned EW   = N_IN + 1;

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  state_t            state, state_nxt;
  logic [N_IN-1:0]   idx, idx_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic [NVEC-1:0]   tt, tt_nxt;
  logic [N_IN-1:0]   dut_in_nxt;
  logic              busy_nxt, done_nxt, pass_nxt, fail_valid_nxt;
  logic [EW-1:0]     err_count_nxt;
  logic [N_IN-1:0]   first_fail_nxt;

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      cnt        <= '0;
      tt         <= '0;
      dut_in     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      first_fail <= '0;
      fail_valid <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      cnt        <= cnt_nxt;
      tt         <= tt_nxt;
      dut_in     <= dut_in_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      pass       <= pass_nxt;
      err_count  <= err_count_nxt;
      first_fail <= first_fail_nxt;
      fail_valid <= fail_valid_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt      = state;
    idx_nxt        = idx;
    cnt_nxt        = cnt;
    tt_nxt         = tt;
    dut_in_nxt     = dut_in;
    busy_nxt       = busy;
    done_nxt       = 1'b0;
    pass_nxt       = pass;
    err_count_nxt  = err_count;
    first_fail_nxt = first_fail;
    fail_valid_nxt = fail_valid;

    unique case (state)
      IDLE: begin
        if (start && !abort) begin
          state_nxt      = DRIVE;
          tt_nxt         = expected_tt;
          idx_nxt        = '0;
          cnt_nxt        = '0;
          dut_in_nxt     = '0;
          err_count_nxt  = '0;
          first_fail_nxt = '0;
          fail_valid_nxt = 1'b0;
          pass_nxt       = 1'b0;
          busy_nxt       = 1'b1;
        end
      end

      DRIVE: begin
        if (abort) begin
          state_nxt  = IDLE;
          busy_nxt   = 1'b0;
          dut_in_nxt = '0;
        end else if (cnt == CW'(SETTLE - 1)) begin
          state_nxt = SAMPLE;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end

      SAMPLE: begin
        // An abort here drops this vector's compare entirely
        if (abort) begin
          state_nxt  = IDLE;
          busy_nxt   = 1'b0;
          dut_in_nxt = '0;
        end else begin
          if (dut_out != tt[idx]) begin
            err_count_nxt = err_count + EW'(1);
            if (!fail_valid) begin
              first_fail_nxt = idx;
              fail_valid_nxt = 1'b1;
            end
          end
          if (idx == N_IN'(NVEC - 1)) begin
            state_nxt  = DONE;
            busy_nxt   = 1'b0;
            done_nxt   = 1'b1;
            dut_in_nxt = '0;
            pass_nxt   = (err_count_nxt == '0);
          end else begin
            state_nxt  = DRIVE;
            idx_nxt    = idx + N_IN'(1);
            dut_in_nxt = idx + N_IN'(1);
            cnt_nxt    = '0;
          end
        end
      end

      DONE: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_gate_tt_sequencer.sv
module tb_gate_tt_sequencer;

  localparam int N   = 3;
  localparam int S   = 2;
  localparam int NV  = 1 << N;
  localparam int L   = NV * (S + 1);   // edge (relative to start) that enters DONE

  localparam int G_OR   = 0;
  localparam int G_AND  = 1;
  localparam int G_ZERO = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [NV-1:0] expected_tt = '0;
  logic [N-1:0]  dut_in;
  logic          dut_out;
  logic          busy, done, pass, fail_valid;
  logic [N:0]    err_count;
  logic [N-1:0]  first_fail;

  int gsel = G_OR;
  int n_cmp = 0;
  int n_bad = 0;

  gate_tt_sequencer #(.N_IN(N), .SETTLE(S)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .expected_tt(expected_tt), .dut_in(dut_in), .dut_out(dut_out),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_fail(first_fail), .fail_valid(fail_valid)
  );

  always #5 clk = ~clk;

  // Gate under test: behavioural OR3 / AND3 / stuck-at-0
  function automatic logic gfun(input int g, input int v);
    logic [N-1:0] b;
    b = N'(v);
    case (g)
      G_OR:    return |b;
      G_AND:   return &b;
      default: return 1'b0;
    endcase
  endfunction

  assign dut_out = gfun(gsel, int'(dut_in));

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", nm, got, exp, $time);
    end
  endtask

  // Sweep model: one record of the most recent accepted start, advanced once
  // per edge; everything observable is derived from the edge offset r.
  bit          m_have = 0;
  int          m_r = 0;
  bit          m_ab = 0;
  int          m_a = 0;
  logic [7:0]  m_tt = '0;
  int          m_g = 0;

  always @(posedge clk or negedge rst_n) begin
    bit idle_before, busy_before;
    if (!rst_n) begin
      m_have = 0;
    end else begin
      idle_before = !m_have || (m_ab ? (m_r >= m_a) : (m_r > L));
      busy_before = m_have && (m_r < L) && !(m_ab && m_r >= m_a);
      if (start && !abort && idle_before) begin
        m_have = 1; m_r = 0; m_ab = 0; m_a = 0;
        m_tt = 8'(expected_tt); m_g = gsel;
      end else if (m_have) begin
        m_r++;
        if (abort && busy_before) begin
          m_ab = 1; m_a = m_r;
        end
      end
    end
  end

  // Compare every cycle against the model
  always @(negedge clk) begin
    int  e_err, e_ff, e_din, ce;
    bit  e_fv, e_busy, e_done, e_pass;
    e_err = 0; e_ff = 0; e_din = 0; e_fv = 0; e_busy = 0; e_done = 0; e_pass = 0;
    if (m_have) begin
      e_busy = (m_r < L) && !(m_ab && m_r >= m_a);
      e_din  = e_busy ? m_r / (S + 1) : 0;
      e_done = (m_r == L) && !m_ab;
      for (int k = 0; k < NV; k++) begin
        ce = (k + 1) * (S + 1);
        if (ce <= m_r && (!m_ab || ce < m_a) && (gfun(m_g, k) != m_tt[k])) begin
          if (!e_fv) e_ff = k;
          e_fv = 1;
          e_err++;
        end
      end
      e_pass = (m_r >= L) && !m_ab && (e_err == 0);
    end
    check("busy", 32'(busy), 32'(e_busy));
    check("done", 32'(done), 32'(e_done));
    check("pass", 32'(pass), 32'(e_pass));
    check("dut_in", 32'(dut_in), 32'(e_din));
    check("err_count", 32'(err_count), 32'(e_err));
    check("fail_valid", 32'(fail_valid), 32'(e_fv));
    if (e_fv) check("first_fail", 32'(first_fail), 32'(e_ff));
  end

  // Start pulse: returns #1 after the accepting edge E0
  task automatic pulse_start(input logic [NV-1:0] tt_v, input int g);
    @(negedge clk);
    gsel = g; expected_tt = tt_v; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Advance to edge n after E0 (caller is #1 after E0), then #1
  task automatic to_edge(input int from_e, input int to_e);
    repeat (to_e - from_e) @(posedge clk);
    #1;
  endtask

  task automatic check_result(input string nm, input int err, input int ff, input int fv, input int ps);
    check({nm, "_done"}, 32'(done), 32'd1);
    check({nm, "_busy"}, 32'(busy), 32'd0);
    check({nm, "_err"}, 32'(err_count), 32'(err));
    check({nm, "_fv"}, 32'(fail_valid), 32'(fv));
    if (fv != 0) check({nm, "_ff"}, 32'(first_fail), 32'(ff));
    check({nm, "_pass"}, 32'(pass), 32'(ps));
  endtask

  initial begin
    #2;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err_count), 32'd0);
    check("rst_dut_in", 32'(dut_in), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // start+abort together while idle: stays idle
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    check("sa_busy", 32'(busy), 32'd0);
    start = 1'b0; abort = 1'b0;

    // OR3 against OR3 table
    pulse_start(8'hFE, G_OR);
    check("t1_e0_busy", 32'(busy), 32'd1);
    check("t1_e0_din", 32'(dut_in), 32'd0);
    to_edge(0, 3);
    check("t1_e3_din", 32'(dut_in), 32'd1);
    to_edge(3, 24);
    check_result("or3", 0, 0, 0, 1);
    repeat (3) @(posedge clk);

    // Stuck-at-0 output
    pulse_start(8'hFE, G_ZERO);
    to_edge(0, 24);
    check_result("zero", 7, 1, 1, 0);
    repeat (3) @(posedge clk);

    // AND3 against OR3 table
    pulse_start(8'hFE, G_AND);
    to_edge(0, 24);
    check_result("and3", 6, 1, 1, 0);
    repeat (3) @(posedge clk);

    // Re-pulsed start at edges 5 and 12 is ignored
    pulse_start(8'hFE, G_AND);
    to_edge(0, 4);
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    to_edge(5, 11);
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    to_edge(12, 23);
    check("rs_e23_done", 32'(done), 32'd0);
    to_edge(23, 24);
    check_result("restart", 6, 1, 1, 0);
    repeat (3) @(posedge clk);

    // Abort raised just after edge 10, taken at edge 11
    pulse_start(8'hFE, G_ZERO);
    to_edge(0, 10);
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    check("ab_busy", 32'(busy), 32'd0);
    check("ab_din", 32'(dut_in), 32'd0);
    check("ab_done", 32'(done), 32'd0);
    check("ab_err", 32'(err_count), 32'd2);
    check("ab_ff", 32'(first_fail), 32'd1);
    check("ab_fv", 32'(fail_valid), 32'd1);
    to_edge(11, 30);
    check("ab_pass", 32'(pass), 32'd0);

    // Asynchronous reset mid-sweep, then a clean sweep
    pulse_start(8'hFE, G_ZERO);
    to_edge(0, 14);
    rst_n = 1'b0;
    #1;
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_err", 32'(err_count), 32'd0);
    check("mr_fv", 32'(fail_valid), 32'd0);
    check("mr_din", 32'(dut_in), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);
    check("mr_idle", 32'(busy), 32'd0);
    pulse_start(8'hFE, G_OR);
    to_edge(0, 24);
    check_result("post_rst", 0, 0, 0, 1);
    repeat (4) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
